// File: rtl/pll_ctrl_seq.sv
// DDR3 core PLL power-up/recovery sequencer: reset, filtered lock, clkout0 gating, retry supervision.
// Build option: define PLL_CTRL_AUTO_RELOCK_EN to re-sequence (instead of failing) on lock loss in RUN.
module pll_ctrl_seq #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_FILT    = 64,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int GATE_DLY     = 8,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       clkout0_gate,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RESET  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_FILTER = 3'd3;
  localparam logic [2:0] ST_GATE   = 3'd4;
  localparam logic [2:0] ST_RUN    = 3'd5;
  localparam logic [2:0] ST_FAIL   = 3'd6;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_DLY - 1);

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [1:0] retry_sat_inc(input logic [1:0] r);
    return (r == 2'd3) ? r : r + 2'd1;
  endfunction

  logic             lock_p0;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       state_nxt;
  logic [1:0]       retry_nxt;
  logic             attempt_fail;
  logic             lost;

  // Stage p0/s: two-flop synchronizer for the asynchronous lock
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_p0 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      lock_p0 <= pll_lock;
      lock_s  <= lock_p0;
    end
  end

  always_comb begin
    state_nxt    = state;
    attempt_fail = 1'b0;
    lost         = 1'b0;
    case (state)
      ST_IDLE:   if (enable) state_nxt = ST_RESET;
      ST_RESET:  if (cnt == RST_LAST) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (lock_s)              state_nxt = ST_FILTER;
        else if (cnt == TO_LAST) attempt_fail = 1'b1;
      end
      ST_FILTER: begin
        if (!lock_s)               state_nxt = ST_WAIT;
        else if (cnt == FILT_LAST) state_nxt = ST_GATE;
      end
      ST_GATE: begin
        if (!lock_s)               attempt_fail = 1'b1;
        else if (cnt == GATE_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) begin
          lost = 1'b1;
`ifdef PLL_CTRL_AUTO_RELOCK_EN
          state_nxt = ST_RESET;
`else
          state_nxt = ST_FAIL;
`endif
        end
      end
      ST_FAIL:   state_nxt = ST_FAIL;
      default:   state_nxt = ST_IDLE;
    endcase

    if (attempt_fail)
      state_nxt = (int'(retry_cnt) + 1 >= MAX_RETRY) ? ST_FAIL : ST_RESET;

    // Shutdown request overrides every other transition
    if (!enable) begin
      state_nxt    = ST_IDLE;
      attempt_fail = 1'b0;
      lost         = 1'b0;
    end
  end

  always_comb begin
    retry_nxt = retry_cnt;
    if (state == ST_IDLE && state_nxt == ST_RESET)
      retry_nxt = 2'd0;
    else if (attempt_fail)
      retry_nxt = retry_sat_inc(retry_cnt);
`ifdef PLL_CTRL_AUTO_RELOCK_EN
    if (state_nxt == ST_RUN && state != ST_RUN)
      retry_nxt = 2'd0;
`endif
  end

  // Shared counter restarts on every state change
  always_comb begin
    cnt_nxt = cnt;
    if (state_nxt != state)
      cnt_nxt = '0;
    else if (state == ST_RESET || state == ST_WAIT || state == ST_FILTER || state == ST_GATE)
      cnt_nxt = cnt_sat_inc(cnt);
  end

  // Outputs registered from the next state so they align with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      retry_cnt    <= 2'd0;
      pll_rst      <= 1'b1;
      clkout0_gate <= 1'b0;
      ready        <= 1'b0;
      fail         <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      retry_cnt    <= retry_nxt;
      pll_rst      <= (state_nxt == ST_IDLE) || (state_nxt == ST_RESET) || (state_nxt == ST_FAIL);
      clkout0_gate <= (state_nxt == ST_RUN);
      ready        <= (state_nxt == ST_RUN);
      fail         <= (state_nxt == ST_FAIL);
      lock_lost    <= lost;
    end
  end

endmodule
